// File: rtl/alu_pkg.sv
// Shared constants and types for the bit-serial ALU sequencer.
package alu_pkg;
    localparam int WIDTH    = 24;
    localparam int BINV_BIT = 2;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b011;

    localparam logic [1:0] OPN_AND = 2'b00;
    localparam logic [1:0] OPN_OR  = 2'b01;
    localparam logic [1:0] OPN_ADD = 2'b10;
    localparam logic [1:0] OPN_XOR = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between the control unit and the serial ALU.
interface alu_serial_ctrl_if #(parameter int W = alu_pkg::WIDTH);
    logic         start;
    logic [2:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         cout;
    logic         overflow;

    modport master (output start, opcode, a, b,
                    input  busy, done, result, zero, cout, overflow);
    modport slave  (input  start, opcode, a, b,
                    output busy, done, result, zero, cout, overflow);
endinterface

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: optional B inversion, AND/OR/ADD/XOR selected by OPERATION.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_cin,
    input  logic       i_binvert,
    input  logic [1:0] i_operation,
    output logic       o_result,
    output logic       o_cout
);
    logic w_b_eff;
    logic w_sum;

    assign w_b_eff = i_binvert ? ~i_b : i_b;
    assign w_sum   = i_a ^ w_b_eff ^ i_cin;
    assign o_cout  = (i_a & w_b_eff) | (i_cin & (i_a ^ w_b_eff));

    // 4:1 result mux
    always_comb begin
        o_result = 1'b0;
        case (i_operation)
            OPN_AND: o_result = i_a & w_b_eff;
            OPN_OR:  o_result = i_a | w_b_eff;
            OPN_ADD: o_result = w_sum;
            OPN_XOR: o_result = i_a ^ w_b_eff;
            default: o_result = 1'b0;
        endcase
    end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: feeds one ALU slice LSB-first for WIDTH cycles and
// publishes the result with ZERO/COUT/OVERFLOW on a one-cycle DONE.
module alu_serial_ctrl
    import alu_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    alu_serial_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a_sh, r_b_sh, r_res_sh, r_result;
    logic [2:0]         r_op;
    logic [CW-1:0]      r_cnt;
    logic               r_carry, r_zero, r_cout, r_ovf, r_done;
    logic               w_bit, w_cout, w_last, w_arith;
    logic [WIDTH-1:0]   w_final;

    alu_bit_slice u_slice (
        .i_a         (r_a_sh[0]),
        .i_b         (r_b_sh[0]),
        .i_cin       (r_carry),
        .i_binvert   (r_op[BINV_BIT]),
        .i_operation (r_op[1:0]),
        .o_result    (w_bit),
        .o_cout      (w_cout)
    );

    assign w_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_arith = (r_op[1:0] == OPN_ADD);
    // Complete result including the bit the slice is producing right now.
    assign w_final = {w_bit, r_res_sh[WIDTH-1:1]};

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; START is only honoured in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = RUN;
            RUN:     if (w_last)    w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand latch, serial shift, and result/flag publication.
    // Outputs are written on the edge entering FIN so they are valid while
    // DONE is high; at that edge r_carry still holds the MSB carry-in, which
    // is exactly the c_msb term of the overflow check.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_a_sh   <= bus.a;
                    r_b_sh   <= bus.b;
                    r_op     <= bus.opcode;
                    r_carry  <= bus.opcode[BINV_BIT];
                    r_cnt    <= '0;
                    r_res_sh <= '0;
                end
                RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_final;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                        r_cout   <= w_arith & w_cout;
                        r_ovf    <= w_arith & (r_carry ^ w_cout);
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed and randomized checks of alu_serial_ctrl against an arithmetic model.
module tb_alu_serial_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_serial_ctrl_if bus();

    alu_serial_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the effective operands.
    function automatic void model(input logic [23:0] a, input logic [23:0] b, input logic [2:0] op,
                                  output logic [23:0] r, output logic c, output logic v);
        logic [23:0] bb;
        logic [24:0] s;
        bb = op[2] ? ~b : b;
        c = 1'b0;
        v = 1'b0;
        case (op[1:0])
            2'b00: r = a & bb;
            2'b01: r = a | bb;
            2'b11: r = a ^ bb;
            default: begin
                s = {1'b0, a} + {1'b0, bb} + 25'(op[2]);
                r = s[23:0];
                c = s[24];
                v = (a[23] == bb[23]) && (r[23] != a[23]);
            end
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [23:0] a, input logic [23:0] b, input logic [2:0] op);
        logic [23:0] er, prev;
        logic ec, ev;
        int n;
        model(a, b, op, er, ec, ev);
        @(negedge clk);
        prev = bus.result;
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.opcode = op;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 24'($urandom); bus.b = 24'($urandom); bus.opcode = 3'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
            if (n == 10) chk({tag, "_hold"}, 32'(bus.result), 32'(prev));
        end
        chk({tag, "_lat"}, 32'(n), 32'd24);
        chk({tag, "_res"}, 32'(bus.result), 32'(er));
        chk({tag, "_zero"}, 32'(bus.zero), 32'(er == 24'd0));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ev));
        @(posedge clk); @(negedge clk);
        chk({tag, "_done1"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [23:0] er1, er2;
        logic ec, ev;
        int ndone, dedge, n;

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res",  32'(bus.result), 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        rst_n = 1'b1;

        run_op("add",   24'h000001, 24'h000002, OP_ADD);
        run_op("sub",   24'h000005, 24'h000005, OP_SUB);
        run_op("ovf",   24'h7FFFFF, 24'h000001, OP_ADD);
        run_op("carry", 24'hFFFFFF, 24'h000001, OP_ADD);
        run_op("xor",   24'hF0F0F0, 24'hFF00FF, OP_XOR);
        run_op("and",   24'hF0F0F0, 24'hFF00FF, OP_AND);
        run_op("andn",  24'hF0F0F0, 24'hFF00FF, 3'b100);
        run_op("orn",   24'h0F0000, 24'h00FFFF, 3'b101);

        // START held high; A changed mid-run must not disturb the first op.
        model(24'h123456, 24'h000111, OP_ADD, er1, ec, ev);
        model(24'h654321, 24'h000111, OP_ADD, er2, ec, ev);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 24'h123456; bus.b = 24'h000111; bus.opcode = OP_ADD;
        @(posedge clk);
        ndone = 0; dedge = 0;
        for (int e = 1; e <= 26; e++) begin
            @(posedge clk); @(negedge clk);
            if (e == 5) bus.a = 24'h654321;
            if (bus.done) begin
                ndone++; dedge = e;
                chk("holdst_res", 32'(bus.result), 32'(er1));
            end
            if (e == 25) chk("holdst_fin_idle", 32'(bus.busy), 32'd0);
            if (e == 26) chk("holdst_reaccept", 32'(bus.busy), 32'd1);
        end
        chk("holdst_ndone", 32'(ndone), 32'd1);
        chk("holdst_edge", 32'(dedge), 32'd24);
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); @(negedge clk); n++;
        end
        chk("holdst2_lat", 32'(n), 32'd24);
        chk("holdst2_res", 32'(bus.result), 32'(er2));

        // Reset in the middle of a run discards it and clears outputs.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 24'h00ABCD; bus.b = 24'h001111; bus.opcode = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_res",  32'(bus.result), 32'd0);
        chk("mrst_zero", 32'(bus.zero), 32'd0);
        chk("mrst_cout", 32'(bus.cout), 32'd0);
        chk("mrst_ovf",  32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mrst_nodone", 32'(ndone), 32'd0);
        run_op("post_rst", 24'h00ABCD, 24'h001111, OP_SUB);

        // Randomized operands and opcodes.
        for (int i = 0; i < 20; i++)
            run_op("rnd", 24'($urandom), 24'($urandom), 3'($urandom_range(7, 0)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
